// File: rtl/csel_addsub_pipe_pkg.sv
// Shared constants and types for the pipelined carry-select adder/subtractor.
package csel_addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned BLK_MAX = 16;

  // Bit n set means a block width of n is supported (4, 8 and 16).
  localparam logic [31:0] BLK_LEGAL_MASK = 32'h0001_0110;

  // Speculative pair of one block; sums are zero-extended to the widest legal block.
  typedef struct packed {
    logic [BLK_MAX-1:0] sum0;
    logic               c0;
    logic [BLK_MAX-1:0] sum1;
    logic               c1;
  } blk_res_t;

  function automatic logic blk_is_legal(input int unsigned blk);
    return (blk <= BLK_MAX) && BLK_LEGAL_MASK[5'(blk)];
  endfunction

endpackage

// File: rtl/csel_addsub_pipe_if.sv
// Operand/result handshake bundle of csel_addsub_pipe.
interface csel_addsub_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );
endinterface

// File: rtl/csel_addsub_pipe_block.sv
// BLK-bit ripple adder used for each carry-select block.
module csel_block #(
  parameter int unsigned BLK = 8
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] sum_c,
  output logic           cout_c
);
  assign {cout_c, sum_c} = (BLK+1)'(a) + (BLK+1)'(b) + (BLK+1)'(cin);
endmodule

// File: rtl/csel_addsub_pipe.sv
// Two-stage carry-select add/sub with valid/ready handshake.
// Optional ovf/zero flags are built when CSEL_ADDSUB_FLAGS_EN is defined.
module csel_addsub_pipe
  import csel_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BLK   = 8
) (
  input logic               clk,
  input logic               rst_n,
  csel_addsub_pipe_if.slave bus
);
  localparam int unsigned NBLK = WIDTH / BLK;

  if (((WIDTH % BLK) != 0) || (WIDTH < 8) || !blk_is_legal(BLK)) begin : g_cfg_err
    $error("csel_addsub_pipe: WIDTH must be a multiple of BLK (>= 8) and BLK one of 4/8/16");
  end

  logic             s1_adv;
  logic             s2_adv;
  logic             s1_valid;
  logic             out_valid_q;
  logic [WIDTH-1:0] b_x;
  logic             cin0;
  blk_res_t         res_c  [NBLK];
  blk_res_t         s1_res [NBLK];
  logic [WIDTH-1:0] sum_c;
  logic [NBLK:0]    csel;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  assign s2_adv       = !out_valid_q || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;

  assign b_x  = (bus.in_sub == OP_SUB) ? ~bus.in_b : bus.in_b;
  assign cin0 = (bus.in_sub == OP_ADD) ? bus.in_cin : 1'b1;

  // Block 0 resolves directly; upper blocks compute both carry-in cases.
  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    if (k == 0) begin : g_lsb
      logic [BLK-1:0] s;
      logic           co;
      csel_block #(.BLK(BLK)) u_add (
        .a(bus.in_a[0 +: BLK]), .b(b_x[0 +: BLK]), .cin(cin0), .sum_c(s), .cout_c(co)
      );
      assign res_c[k] = '{sum0: BLK_MAX'(s), c0: co, sum1: BLK_MAX'(s), c1: co};
    end else begin : g_spec
      logic [BLK-1:0] s0, s1;
      logic           co0, co1;
      csel_block #(.BLK(BLK)) u_add0 (
        .a(bus.in_a[k*BLK +: BLK]), .b(b_x[k*BLK +: BLK]), .cin(1'b0), .sum_c(s0), .cout_c(co0)
      );
      csel_block #(.BLK(BLK)) u_add1 (
        .a(bus.in_a[k*BLK +: BLK]), .b(b_x[k*BLK +: BLK]), .cin(1'b1), .sum_c(s1), .cout_c(co1)
      );
      assign res_c[k] = '{sum0: BLK_MAX'(s0), c0: co0, sum1: BLK_MAX'(s1), c1: co1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : s1_regs
    if (!rst_n) begin
      s1_valid <= 1'b0;
      for (int k = 0; k < NBLK; k++) s1_res[k] <= '0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) s1_res <= res_c;
    end
  end

  // Select chain: block 0 holds its resolved result in both halves, so csel[0] is don't-care.
  assign csel[0] = 1'b0;
  for (genvar k = 0; k < NBLK; k++) begin : g_sel
    logic [BLK_MAX-1:0] pick;
    assign pick                 = csel[k] ? s1_res[k].sum1 : s1_res[k].sum0;
    assign sum_c[k*BLK +: BLK]  = BLK'(pick);
    assign csel[k+1]            = csel[k] ? s1_res[k].c1 : s1_res[k].c0;
  end

  always_ff @(posedge clk or negedge rst_n) begin : s2_regs
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        sum_q  <= sum_c;
        cout_q <= csel[NBLK];
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;

`ifdef CSEL_ADDSUB_FLAGS_EN
  logic s1_sa, s1_sb, ovf_q, zero_q;

  always_ff @(posedge clk or negedge rst_n) begin : sign_regs
    if (!rst_n) begin
      s1_sa <= 1'b0;
      s1_sb <= 1'b0;
    end else if (s1_adv && bus.in_valid) begin
      s1_sa <= bus.in_a[WIDTH-1];
      s1_sb <= b_x[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : flag_regs
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (s2_adv && s1_valid) begin
      ovf_q  <= (s1_sa == s1_sb) && (sum_c[WIDTH-1] != s1_sa);
      zero_q <= ~|sum_c;
    end
  end

  assign bus.out_ovf  = ovf_q;
  assign bus.out_zero = zero_q;
`else
  assign bus.out_ovf  = 1'b0;
  assign bus.out_zero = 1'b0;
`endif

endmodule
